// File: rtl/trap_sequencer.sv
// trap_sequencer: arbitrates synchronous exceptions and interrupts into a
// four-state trap commit sequence (capture, flush, redirect+commit).
module trap_sequencer #(
  parameter int NUM_SRC = 4,
  parameter int CODE_W = 5,
  parameter int ID_W = 3,
  parameter logic [CODE_W-1:0] IRQ_CODE = CODE_W'(11)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        req_valid,
  input  logic [NUM_SRC*CODE_W-1:0] req_code,
  input  logic [NUM_SRC*32-1:0]     req_tval,
  input  logic [NUM_SRC*ID_W-1:0]   req_id,
  output logic [NUM_SRC-1:0]        req_ack,
  input  logic                      irq,
  input  logic                      irq_en,
  input  logic                      pipeline_idle,
  output logic                      issue_hold,
  output logic                      fetch_flush,
  output logic                      fetch_pc_override,
  output logic                      trap_valid,
  output logic [CODE_W-1:0]         trap_code,
  output logic [31:0]               trap_tval,
  output logic [ID_W-1:0]           trap_id,
  output logic                      trap_is_irq,
  output logic [7:0]                trap_count
);
  localparam logic [1:0] IDLE = 2'd0, DRAIN = 2'd1, FLUSH1 = 2'd2, FLUSH2 = 2'd3;
  logic [1:0] state, state_nxt;
  logic [NUM_SRC-1:0] grant;
  logic [CODE_W-1:0] sel_code;
  logic [31:0] sel_tval;
  logic [ID_W-1:0] sel_id;
  logic any_req, accept, irq_take;
  // descending scan leaves the lowest set index as the winner
  always_comb begin
    grant = '0;
    sel_code = '0;
    sel_tval = '0;
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (req_valid[i]) begin
        grant = '0;
        grant[i] = 1'b1;
        sel_code = req_code[i*CODE_W +: CODE_W];
        sel_tval = req_tval[i*32 +: 32];
        sel_id = req_id[i*ID_W +: ID_W];
      end
  end
  assign any_req = |req_valid;
  assign accept = rst && any_req && (state == IDLE || state == DRAIN);
  assign irq_take = rst && !any_req && state == DRAIN && irq && irq_en && pipeline_idle;
  always_comb
    state_nxt = (accept || irq_take) ? FLUSH1 :
                state == FLUSH1 ? FLUSH2 :
                state == FLUSH2 ? IDLE :
                (irq && irq_en) ? DRAIN : IDLE;
  assign req_ack = accept ? grant : '0;
  assign issue_hold = rst && state != IDLE;
  assign fetch_flush = rst && state == FLUSH1;
  assign fetch_pc_override = rst && state == FLUSH2;
  assign trap_valid = rst && state == FLUSH2;
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      trap_code <= '0;
      trap_tval <= '0;
      trap_id <= '0;
      trap_is_irq <= 1'b0;
      trap_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        trap_code <= sel_code;
        trap_tval <= sel_tval;
        trap_id <= sel_id;
        trap_is_irq <= 1'b0;
      end else if (irq_take) begin
        trap_code <= IRQ_CODE;
        trap_tval <= '0;
        trap_id <= '0;
        trap_is_irq <= 1'b1;
      end
      if (state == FLUSH2 && trap_count != 8'hff) trap_count <= trap_count + 8'd1;
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: table vectors, directed corner sequences and random
// traffic checked against a cycle-timeline reference model.
module tb_trap_sequencer;
  localparam int N = 4, CW = 5, IW = 3;
  logic clk = 0, rst = 0;
  logic [N-1:0] req_valid = '0;
  logic [N*CW-1:0] req_code = '0;
  logic [N*32-1:0] req_tval = '0;
  logic [N*IW-1:0] req_id = '0;
  logic irq = 0, irq_en = 0, pipeline_idle = 0;
  logic [N-1:0] req_ack;
  logic issue_hold, fetch_flush, fetch_pc_override, trap_valid, trap_is_irq;
  logic [CW-1:0] trap_code;
  logic [31:0] trap_tval;
  logic [IW-1:0] trap_id;
  logic [7:0] trap_count;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  trap_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_code(req_code),
    .req_tval(req_tval), .req_id(req_id), .req_ack(req_ack), .irq(irq),
    .irq_en(irq_en), .pipeline_idle(pipeline_idle), .issue_hold(issue_hold),
    .fetch_flush(fetch_flush), .fetch_pc_override(fetch_pc_override),
    .trap_valid(trap_valid), .trap_code(trap_code), .trap_tval(trap_tval),
    .trap_id(trap_id), .trap_is_irq(trap_is_irq), .trap_count(trap_count)
  );

  // Reference model: a trap accepted at cycle t flushes at t+1, commits at
  // t+2 and frees the sequencer at t+3; waiting marks an interrupt drain.
  int cyc = 0, acc_cyc = -10, free_at = 0, m_count = 0;
  bit waiting = 0, m_irq = 0;
  logic [CW-1:0] m_code = '0;
  logic [31:0] m_tval = '0;
  logic [IW-1:0] m_id = '0;
  logic [N-1:0] e_ack;
  bit e_free, e_any, e_flush, e_valid, e_hold;
  int e_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic eval();
    #1;
    e_free = cyc >= free_at;
    e_any = |req_valid;
    e_lo = -1;
    for (int i = N - 1; i >= 0; i--) if (req_valid[i]) e_lo = i;
    e_ack = '0;
    if (rst && e_free && e_any) e_ack[e_lo] = 1'b1;
    e_flush = rst && cyc == acc_cyc + 1;
    e_valid = rst && cyc == acc_cyc + 2;
    e_hold = rst && (waiting || !e_free);
    chk("req_ack", 32'(req_ack), 32'(e_ack));
    chk("issue_hold", 32'(issue_hold), 32'(e_hold));
    chk("fetch_flush", 32'(fetch_flush), 32'(e_flush));
    chk("fetch_pc_override", 32'(fetch_pc_override), 32'(e_valid));
    chk("trap_valid", 32'(trap_valid), 32'(e_valid));
    chk("trap_code", 32'(trap_code), 32'(m_code));
    chk("trap_tval", trap_tval, m_tval);
    chk("trap_id", 32'(trap_id), 32'(m_id));
    chk("trap_is_irq", 32'(trap_is_irq), 32'(m_irq));
    chk("trap_count", 32'(trap_count), 32'(m_count));
  endtask

  task automatic adv();
    if (!rst) begin
      acc_cyc = cyc - 10; free_at = 0; waiting = 0; m_count = 0;
      m_code = '0; m_tval = '0; m_id = '0; m_irq = 0;
    end else begin
      if (e_valid && m_count < 255) m_count++;
      if (e_free && e_any) begin
        m_code = req_code[e_lo*CW +: CW];
        m_tval = req_tval[e_lo*32 +: 32];
        m_id = req_id[e_lo*IW +: IW];
        m_irq = 0; acc_cyc = cyc; free_at = cyc + 3; waiting = 0;
      end else if (e_free && waiting && irq && irq_en && pipeline_idle) begin
        m_code = 5'd11; m_tval = '0; m_id = '0;
        m_irq = 1; acc_cyc = cyc; free_at = cyc + 3; waiting = 0;
      end else if (e_free) waiting = irq && irq_en;
    end
    @(negedge clk);
    cyc++;
    req_valid = req_valid & ~e_ack;
  endtask

  task automatic step();
    eval();
    adv();
  endtask

  task automatic set_src(input int i, input logic [CW-1:0] c, input logic [31:0] t, input logic [IW-1:0] d);
    req_code[i*CW +: CW] = c;
    req_tval[i*32 +: 32] = t;
    req_id[i*IW +: IW] = d;
  endtask

  typedef struct {
    logic [N-1:0] rv;
    logic irq, en, pidle;
    logic [N-1:0] ack;
    logic hold, flush, valid;
    logic [CW-1:0] code;
    logic is_irq;
  } vec_t;
  vec_t tbl[12];

  initial begin
    tbl[0]  = '{4'b0110, 0, 0, 0, 4'b0010, 0, 0, 0, 5'd0, 0};
    tbl[1]  = '{4'b0100, 0, 0, 0, 4'b0000, 1, 1, 0, 5'd2, 0};
    tbl[2]  = '{4'b0100, 0, 0, 0, 4'b0000, 1, 0, 1, 5'd2, 0};
    tbl[3]  = '{4'b0100, 0, 0, 0, 4'b0100, 0, 0, 0, 5'd2, 0};
    tbl[4]  = '{4'b0000, 0, 0, 0, 4'b0000, 1, 1, 0, 5'd4, 0};
    tbl[5]  = '{4'b0000, 0, 0, 0, 4'b0000, 1, 0, 1, 5'd4, 0};
    tbl[6]  = '{4'b0000, 1, 1, 0, 4'b0000, 0, 0, 0, 5'd4, 0};
    tbl[7]  = '{4'b0000, 1, 1, 0, 4'b0000, 1, 0, 0, 5'd4, 0};
    tbl[8]  = '{4'b0000, 1, 1, 1, 4'b0000, 1, 0, 0, 5'd4, 0};
    tbl[9]  = '{4'b0000, 1, 1, 1, 4'b0000, 1, 1, 0, 5'd11, 1};
    tbl[10] = '{4'b0000, 0, 1, 1, 4'b0000, 1, 0, 1, 5'd11, 1};
    tbl[11] = '{4'b0000, 0, 1, 1, 4'b0000, 0, 0, 0, 5'd11, 1};
    set_src(0, 5'd6, 32'h1000_0000, 3'd1);
    set_src(1, 5'd2, 32'h1111_1111, 3'd2);
    set_src(2, 5'd4, 32'h2222_2222, 3'd5);
    set_src(3, 5'd9, 32'h3333_3333, 3'd7);
    @(negedge clk);
    @(negedge clk);
    step();
    rst = 1;
    foreach (tbl[k]) begin
      req_valid = tbl[k].rv;
      irq = tbl[k].irq; irq_en = tbl[k].en; pipeline_idle = tbl[k].pidle;
      eval();
      chk($sformatf("tbl%0d_ack", k), 32'(req_ack), 32'(tbl[k].ack));
      chk($sformatf("tbl%0d_hold", k), 32'(issue_hold), 32'(tbl[k].hold));
      chk($sformatf("tbl%0d_flush", k), 32'(fetch_flush), 32'(tbl[k].flush));
      chk($sformatf("tbl%0d_valid", k), 32'(trap_valid), 32'(tbl[k].valid));
      chk($sformatf("tbl%0d_code", k), 32'(trap_code), 32'(tbl[k].code));
      chk($sformatf("tbl%0d_is_irq", k), 32'(trap_is_irq), 32'(tbl[k].is_irq));
      adv();
    end
    irq = 0; irq_en = 0; pipeline_idle = 0;
    // long drain: hold must stay high while the pipeline is busy
    irq = 1; irq_en = 1;
    step();
    for (int k = 0; k < 5; k++) begin
      eval();
      chk("drain_hold", 32'(issue_hold), 32'd1);
      adv();
    end
    pipeline_idle = 1;
    step(); step();
    eval();
    chk("drain_commit", 32'(trap_valid), 32'd1);
    chk("drain_tval", trap_tval, 32'd0);
    adv();
    irq = 0;
    step();
    // synchronous request preempts an in-progress drain
    irq = 1; irq_en = 1; pipeline_idle = 0;
    step(); step();
    req_valid = 4'b0001;
    eval();
    chk("preempt_ack", 32'(req_ack), 32'd1);
    adv();
    step();
    eval();
    chk("preempt_code", 32'(trap_code), 32'd6);
    chk("preempt_is_irq", 32'(trap_is_irq), 32'd0);
    adv();
    pipeline_idle = 1;
    for (int k = 0; k < 5; k++) step();
    chk("preempt_irq_after", 32'(trap_is_irq), 32'd1);
    irq = 0; irq_en = 0;
    step();
    // reset asserted mid-flush aborts the trap
    req_valid = 4'b1000;
    step();
    rst = 0;
    step();
    rst = 1;
    eval();
    chk("abort_valid", 32'(trap_valid), 32'd0);
    chk("abort_count", 32'(trap_count), 32'd0);
    adv();
    // saturation
    for (int k = 0; k < 256; k++) begin
      req_valid = 4'b1000;
      step(); step(); step();
    end
    step();
    chk("sat_count", 32'(trap_count), 32'd255);
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 6) == 0) begin
          req_valid[i] = 1'b1;
          set_src(i, CW'($urandom), $urandom, IW'($urandom));
        end
      if ($urandom_range(0, 7) == 0) irq = ~irq;
      if ($urandom_range(0, 15) == 0) irq_en = ~irq_en;
      pipeline_idle = $urandom_range(0, 2) != 0;
      rst = $urandom_range(0, 299) != 0;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
